// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM state encoding and frame line levels.
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_drain_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1, tick on the last count, clear restarts at 0.
module baud_cnt #(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned CW      = $clog2(CLK_DIV)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pulls words from the byte FIFO read port and drives the TX pin.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned CW      = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  input  logic          fifo_busy,
  output logic          fifo_stb,
  output logic          fifo_op,
  output logic          tx,
  output logic          busy
);

  localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic          tx_q, tx_d;
  logic          baud_clr;
  logic          baud_tick;

  baud_cnt #(
    .CLK_DIV (CLK_DIV),
    .CW      (CW)
  ) u_baud_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (baud_clr),
    .tick    (baud_tick)
  );

  // Next-state logic; the counter is held clear in IDLE/FETCH so START begins at count 0.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    baud_clr  = 1'b0;
    fifo_stb  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_clr = 1'b1;
        tx_d     = IDLE_LVL;
        if (!fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        baud_clr = 1'b1;
        fifo_stb = !fifo_busy;
        if (!fifo_busy) begin
          shift_d = fifo_data;
          state_d = START;
          tx_d    = START_LVL;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IW'(DW - 1)) begin
            state_d = STOP;
            tx_d    = STOP_LVL;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            tx_d      = shift_d[0];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          tx_d    = IDLE_LVL;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LVL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  assign fifo_op = fifo_stb;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);

endmodule
